// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution engine: FSM state
// encoding and the width helpers that size indices, outputs and the total.
package conv_pkg;

   // FSM state encoding (IDLE, MAC, EMIT, DONE)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MAC  = 2'd1;
   localparam state_t ST_EMIT = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   // Width of an index counting 0..n-1; never narrower than one bit so that
   // degenerate sizes (n == 1) still give a legal vector.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Output pixel width: one product plus enough headroom for K*K of them.
   function automatic int acc_w(input int pix_w, input int wgt_w, input int k);
      return pix_w + wgt_w + $clog2(k * k);
   endfunction

   // Running-total width: one output pixel plus headroom for the whole map.
   function automatic int sum_w(input int acc_width, input int out_n);
      return acc_width + $clog2(out_n * out_n);
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Sequential multiply-accumulate datapath: one unsigned pixel*weight product
// per enabled cycle, cleared to zero before each output pixel.
module conv_mac
   import conv_pkg::*;
#(
   parameter int PIX_W = 1,
   parameter int WGT_W = 4,
   parameter int ACC_W = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [PIX_W-1:0] pix,
   input  logic [WGT_W-1:0] wgt,
   output logic [ACC_W-1:0] acc
);

   logic [ACC_W-1:0] prod;

   // Product widened to the accumulator width; cannot overflow by construction
   always_comb begin
      prod = ACC_W'(pix) * ACC_W'(wgt);
   end

   // Accumulator: clear has priority over accumulate
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/conv_engine.sv
// Streaming valid-convolution engine. Rows of an IMG_N x IMG_N image are
// loaded one per handshake, a K x K weight kernel is programmable, and on
// start every output pixel is computed with K*K sequential MAC cycles and
// offered on a valid/ready port while a running total is kept.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. row_valid/row_ready load image rows; out_valid/out_ready
// deliver output pixels. Once out_valid is raised, out_data, out_row,
// out_col and out_last hold steady until the transfer happens.
module conv_engine
   import conv_pkg::*;
#(
   parameter int IMG_N = 6,
   parameter int K     = 3,
   parameter int PIX_W = 1,
   parameter int WGT_W = 4
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               row_valid,
   input  logic [IMG_N*PIX_W-1:0]                             row_data,
   output logic                                               row_ready,
   output logic                                               img_full,
   input  logic                                               clear,
   input  logic                                               wgt_we,
   input  logic [idx_w(K*K)-1:0]                              wgt_addr,
   input  logic [WGT_W-1:0]                                   wgt_data,
   input  logic                                               start,
   output logic                                               busy,
   output logic                                               done,
   output logic                                               out_valid,
   input  logic                                               out_ready,
   output logic [acc_w(PIX_W, WGT_W, K)-1:0]                  out_data,
   output logic [idx_w(IMG_N-K+1)-1:0]                        out_row,
   output logic [idx_w(IMG_N-K+1)-1:0]                        out_col,
   output logic                                               out_last,
   output logic [sum_w(acc_w(PIX_W, WGT_W, K), IMG_N-K+1)-1:0] total_sum,
   output logic [1:0]                                         state_dbg
);

   localparam int OUT_N = IMG_N - K + 1;
   localparam int NW    = K * K;
   localparam int ACC_W = acc_w(PIX_W, WGT_W, K);
   localparam int SUM_W = sum_w(ACC_W, OUT_N);
   localparam int OW    = idx_w(OUT_N);
   localparam int KW    = idx_w(K);
   localparam int AW    = idx_w(NW);
   localparam int RW    = idx_w(IMG_N);

   state_t                   state;
   logic [IMG_N*PIX_W-1:0]   img_mem [IMG_N];
   logic [WGT_W-1:0]         wgt_mem [NW];
   logic [RW-1:0]            row_cnt;
   logic                     full_q;
   logic [OW-1:0]            r;
   logic [OW-1:0]            c;
   logic [KW-1:0]            kr;
   logic [KW-1:0]            kc;
   logic [AW-1:0]            kidx;
   logic                     last_q;
   logic [SUM_W-1:0]         sum_q;
   logic [ACC_W-1:0]         acc;

   logic                     idle;
   logic                     start_ok;
   logic                     row_take;
   logic                     wgt_ok;
   logic                     accept;
   logic                     mac_last;
   logic                     at_last;
   logic                     mac_clr;
   logic                     mac_en;
   logic [RW-1:0]            row_i;
   logic [RW-1:0]            col_i;
   logic [PIX_W-1:0]         pix;
   logic [WGT_W-1:0]         wsel;

   // Command decode; clear beats start beats row acceptance, and nothing
   // but output handshakes is honoured outside IDLE
   always_comb begin
      idle     = (state == ST_IDLE);
      row_ready = idle && !full_q;
      start_ok = idle && !clear && start && full_q;
      row_take = row_valid && row_ready && !clear;
      wgt_ok   = idle && wgt_we && (32'(wgt_addr) < 32'(NW));
      accept   = (state == ST_EMIT) && out_ready;
      mac_last = (kidx == AW'(NW - 1));
      at_last  = (r == OW'(OUT_N - 1)) && (c == OW'(OUT_N - 1));
      mac_clr  = start_ok || (accept && !at_last);
      mac_en   = (state == ST_MAC);
   end

   // Operand fetch for the current kernel tap of the current output pixel
   always_comb begin
      row_i = RW'(r) + RW'(kr);
      col_i = RW'(c) + RW'(kc);
      pix   = img_mem[row_i][int'(col_i)*PIX_W +: PIX_W];
      wsel  = wgt_mem[kidx];
   end

   // Main FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start_ok) state <= ST_MAC;
            ST_MAC:  if (mac_last) state <= ST_EMIT;
            ST_EMIT: if (accept)   state <= at_last ? ST_DONE : ST_MAC;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Image row storage and fill tracking; clear only rewinds the counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IMG_N; i++) img_mem[i] <= '0;
         row_cnt <= '0;
         full_q  <= 1'b0;
      end else if (idle && clear) begin
         row_cnt <= '0;
         full_q  <= 1'b0;
      end else if (row_take) begin
         img_mem[row_cnt] <= row_data;
         if (row_cnt == RW'(IMG_N - 1)) begin
            row_cnt <= '0;
            full_q  <= 1'b1;
         end else begin
            row_cnt <= row_cnt + RW'(1);
         end
      end
   end

   // Kernel weights; reset restores the all-ones kernel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) wgt_mem[i] <= WGT_W'(1);
      end else if (wgt_ok) begin
         wgt_mem[wgt_addr] <= wgt_data;
      end
   end

   // Kernel tap counters walk (kr,kc) in raster order during MAC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kr   <= '0;
         kc   <= '0;
         kidx <= '0;
      end else if (start_ok || mac_last || (state != ST_MAC)) begin
         kr   <= '0;
         kc   <= '0;
         kidx <= '0;
      end else begin
         kidx <= kidx + AW'(1);
         if (kc == KW'(K - 1)) begin
            kc <= '0;
            kr <= kr + KW'(1);
         end else begin
            kc <= kc + KW'(1);
         end
      end
   end

   // Output pixel position, last marker and running total
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r      <= '0;
         c      <= '0;
         last_q <= 1'b0;
         sum_q  <= '0;
      end else if (start_ok) begin
         r      <= '0;
         c      <= '0;
         last_q <= 1'b0;
         sum_q  <= '0;
      end else if (mac_en && mac_last) begin
         last_q <= at_last;
      end else if (accept) begin
         sum_q  <= sum_q + SUM_W'(acc);
         last_q <= 1'b0;
         if (!at_last) begin
            if (c == OW'(OUT_N - 1)) begin
               c <= '0;
               r <= r + OW'(1);
            end else begin
               c <= c + OW'(1);
            end
         end
      end
   end

   conv_mac #(
      .PIX_W (PIX_W),
      .WGT_W (WGT_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .pix (pix),
      .wgt (wsel),
      .acc (acc)
   );

   // Output port mapping; all values come straight from registers
   always_comb begin
      img_full  = full_q;
      busy      = (state == ST_MAC) || (state == ST_EMIT);
      done      = (state == ST_DONE);
      out_valid = (state == ST_EMIT);
      out_data  = acc;
      out_row   = r;
      out_col   = c;
      out_last  = last_q;
      total_sum = sum_q;
      state_dbg = state;
   end

endmodule

// File: tb/tb_conv_engine.sv
// Bench for conv_engine: drives rows, weights and runs, predicts every
// output pixel from its own image/kernel model into a queue and compares
// each accepted output against the head of that queue.
module tb_conv_engine;

   localparam int IMG_N = 6;
   localparam int K     = 3;
   localparam int PIX_W = 1;
   localparam int WGT_W = 4;
   localparam int OUT_N = IMG_N - K + 1;
   localparam int NOUT  = OUT_N * OUT_N;
   localparam int ACC_W = 9;
   localparam int SUM_W = 13;
   localparam int OW    = 2;
   localparam int AW    = 4;
   localparam int W     = 1 + OW + OW + ACC_W;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   row_valid;
   logic [IMG_N*PIX_W-1:0] row_data;
   logic                   row_ready;
   logic                   img_full;
   logic                   clear;
   logic                   wgt_we;
   logic [AW-1:0]          wgt_addr;
   logic [WGT_W-1:0]       wgt_data;
   logic                   start;
   logic                   busy;
   logic                   done;
   logic                   out_valid;
   logic                   out_ready;
   logic [ACC_W-1:0]       out_data;
   logic [OW-1:0]          out_row;
   logic [OW-1:0]          out_col;
   logic                   out_last;
   logic [SUM_W-1:0]       total_sum;
   logic [1:0]             state_dbg;

   always #5 clk = ~clk;

   conv_engine #(
      .IMG_N (IMG_N),
      .K     (K),
      .PIX_W (PIX_W),
      .WGT_W (WGT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row_valid (row_valid),
      .row_data  (row_data),
      .row_ready (row_ready),
      .img_full  (img_full),
      .clear     (clear),
      .wgt_we    (wgt_we),
      .wgt_addr  (wgt_addr),
      .wgt_data  (wgt_data),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .total_sum (total_sum),
      .state_dbg (state_dbg)
   );

   int                     checks = 0;
   int                     errors = 0;
   int                     done_cnt = 0;
   logic [W-1:0]           exp_q[$];
   logic [IMG_N*PIX_W-1:0] tb_img [IMG_N];
   int                     tb_wgt [K*K];
   int                     tb_rcnt;
   bit                     tb_full;
   int                     exp_total;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < IMG_N; i++) tb_img[i] = '0;
      for (int i = 0; i < K*K; i++) tb_wgt[i] = 1;
      tb_rcnt = 0;
      tb_full = 1'b0;
   endtask

   task automatic load_row(input logic [IMG_N*PIX_W-1:0] d);
      row_valid = 1'b1;
      row_data  = d;
      @(negedge clk);
      check("row_ready", 32'(row_ready), 32'(!tb_full));
      if (!tb_full) begin
         tb_img[tb_rcnt] = d;
         tb_rcnt++;
         if (tb_rcnt == IMG_N) begin
            tb_rcnt = 0;
            tb_full = 1'b1;
         end
      end
      tick();
      row_valid = 1'b0;
   endtask

   // kind: 0 all ones, 1 checkerboard, 2 random
   task automatic load_image(input int kind);
      logic [IMG_N*PIX_W-1:0] d;
      for (int r = 0; r < IMG_N; r++) begin
         for (int c = 0; c < IMG_N; c++) begin
            if (kind == 0) d[c] = 1'b1;
            else if (kind == 1) d[c] = (((r + c) % 2) != 0);
            else d[c] = ($urandom_range(0, 1) != 0);
         end
         load_row(d);
      end
      @(negedge clk);
      check("img_full", 32'(img_full), 32'(tb_full));
      tick();
   endtask

   task automatic write_wgt(input int a, input int v);
      wgt_we   = 1'b1;
      wgt_addr = AW'(a);
      wgt_data = WGT_W'(v);
      tick();
      wgt_we = 1'b0;
      if (a < K*K) tb_wgt[a] = v;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tb_rcnt = 0;
      tb_full = 1'b0;
      @(negedge clk);
      check("clear_full", 32'(img_full), 0);
      check("clear_ready", 32'(row_ready), 1);
      tick();
   endtask

   task automatic push_expected();
      logic [W-1:0] e;
      int s;
      exp_total = 0;
      for (int r = 0; r < OUT_N; r++) begin
         for (int c = 0; c < OUT_N; c++) begin
            s = 0;
            for (int kr = 0; kr < K; kr++)
               for (int kc = 0; kc < K; kc++)
                  s += int'(tb_img[r+kr][(c+kc)*PIX_W +: PIX_W]) * tb_wgt[kr*K+kc];
            exp_total += s;
            e = {((r == OUT_N-1) && (c == OUT_N-1)), OW'(r), OW'(c), ACC_W'(s)};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic start_run();
      if (tb_full) push_expected();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic consume(input bit chk_lat, input int stall_idx, input int stall_n);
      logic [W-1:0] e;
      logic [W-1:0] got;
      int lat;
      int run_sum;
      run_sum = 0;
      for (int i = 0; i < NOUT; i++) begin
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!out_valid && lat < 200);
         if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
         end
         if (i == 0 && chk_lat) check("first_latency", 32'(lat), 32'(K*K+1));
         got = {out_last, out_row, out_col, out_data};
         if (i == stall_idx) begin
            repeat (stall_n) begin
               @(negedge clk);
               check("bp_hold", 32'({out_valid, out_last, out_row, out_col, out_data}), 32'({1'b1, got}));
               check("bp_sum", 32'(total_sum), 32'(run_sum));
            end
         end
         if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_pixel", 32'(got), 32'(e));
         end
         run_sum += int'(out_data);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
      @(negedge clk);
      check("done_pulse", 32'(done), 1);
      check("total_sum", 32'(total_sum), 32'(exp_total));
      tick();
      @(negedge clk);
      check("done_single", 32'(done), 0);
      check("busy_after", 32'(busy), 0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [IMG_N*PIX_W-1:0] d;
      rst       = 1'b1;
      row_valid = 1'b0;
      row_data  = '0;
      clear     = 1'b0;
      wgt_we    = 1'b0;
      wgt_addr  = '0;
      wgt_data  = '0;
      start     = 1'b0;
      out_ready = 1'b0;
      model_reset();

      // reset values
      repeat (2) @(negedge clk);
      check("rst_row_ready", 32'(row_ready), 1);
      check("rst_img_full", 32'(img_full), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out", 32'({out_last, out_row, out_col, out_data}), 0);
      check("rst_total", 32'(total_sum), 0);
      check("rst_state", 32'(state_dbg), 0);
      #3 rst = 1'b0;
      tick();

      // all-ones image, default kernel
      load_image(0);
      start_run();
      consume(1'b1, -1, 0);

      // weight write, start and clear during MAC are ignored
      start_run();
      wgt_we   = 1'b1;
      wgt_addr = '0;
      wgt_data = 4'hF;
      start    = 1'b1;
      clear    = 1'b1;
      @(negedge clk);
      check("mac_busy", 32'(busy), 1);
      check("mac_row_ready", 32'(row_ready), 0);
      tick();
      wgt_we = 1'b0;
      start  = 1'b0;
      clear  = 1'b0;
      consume(1'b0, -1, 0);

      // backpressure on output (1,2)
      start_run();
      consume(1'b0, 1*OUT_N+2, 5);

      // centre-tap kernel on a checkerboard
      for (int i = 0; i < K*K; i++) write_wgt(i, (i == 4) ? 1 : 0);
      write_wgt(12, 7);
      do_clear();
      load_image(1);
      start_run();
      consume(1'b1, -1, 0);

      // start before the image is full, then overfill
      do_clear();
      for (int r = 0; r < 4; r++) load_row(IMG_N'($urandom_range(0, 63)));
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("early_start_busy", 32'({busy, state_dbg}), 0);
         tick();
      end
      for (int r = 4; r < IMG_N; r++) load_row(IMG_N'($urandom_range(0, 63)));
      @(negedge clk);
      check("img_full_6", 32'(img_full), 1);
      tick();
      d = '1;
      load_row(d);
      start_run();
      consume(1'b0, -1, 0);
      do_clear();

      // asynchronous reset mid-MAC
      load_image(0);
      start_run();
      repeat (3) tick();
      #3 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_out_valid", 32'(out_valid), 0);
      check("arst_row_ready", 32'(row_ready), 1);
      check("arst_img_full", 32'(img_full), 0);
      check("arst_total", 32'(total_sum), 0);
      check("arst_done", 32'(done), 0);
      @(posedge clk);
      #3 rst = 1'b0;
      exp_q.delete();
      model_reset();
      n = done_cnt;
      repeat (12) tick();
      check("arst_no_done", 32'(done_cnt), 32'(n));

      // after reset the kernel is all ones again
      load_image(0);
      start_run();
      consume(1'b1, -1, 0);

      check("sb_leftover", 32'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv_engine.md
Name: conv_engine

Overview:
Parametrised streaming 2-D convolution engine. It replaces the fixed 6x6 all-ones, sum-only layer.
- Accepts an IMG_N x IMG_N image one row per handshake.
- Holds a programmable K x K unsigned weight kernel.
- On start, computes the valid (no padding) convolution feature map with a sequential MAC.
- Emits each output pixel over a valid/ready interface and keeps a running total for the display path.

Parameters:
IMG_N, 6, image side length in pixels (IMG_N >= K).
K, 3, kernel side length (K >= 1).
PIX_W, 1, bits per image pixel (unsigned; 1 = binary switches).
WGT_W, 4, bits per kernel weight (unsigned).
OUT_N, IMG_N-K+1 (derived), feature map side length.
ACC_W, PIX_W+WGT_W+clog2(K*K) (derived), output pixel width, overflow-free.
SUM_W, ACC_W+clog2(OUT_N*OUT_N) (derived), total_sum width, overflow-free.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
row_valid  in  1  image row offered
row_data  in  IMG_N*PIX_W  row pixels; column c at bits [c*PIX_W +: PIX_W]
row_ready  out  1  engine accepts a row this cycle
img_full  out  1  all IMG_N rows loaded
clear  in  1  discard loaded image (row counter to 0)
wgt_we  in  1  kernel weight write strobe
wgt_addr  in  clog2(K*K)  weight index = kr*K+kc
wgt_data  in  WGT_W  weight value
start  in  1  begin convolution
busy  out  1  high in MAC/EMIT states
done  out  1  one-cycle pulse after last output accepted
out_valid  out  1  output pixel available
out_ready  in  1  consumer accepts output
out_data  out  ACC_W  feature map value
out_row  out  clog2(OUT_N)  output row index
out_col  out  clog2(OUT_N)  output column index
out_last  out  1  marks pixel (OUT_N-1, OUT_N-1)
total_sum  out  SUM_W  sum of all outputs of the current/last run

Behaviour:
Reset values:
- All outputs 0 except row_ready=1.
- Image registers 0; all weights = 1 (legacy all-ones kernel); FSM in IDLE.
- Reset mid-operation aborts immediately; no done pulse.

FSM states: IDLE, MAC, EMIT, DONE.

IDLE:
- row_ready = !img_full.
- A row is accepted when row_valid & row_ready; rows are stored in order 0..IMG_N-1.
- img_full rises the cycle after the IMG_N-th acceptance. row_valid while full is ignored.
- clear: row count to 0, img_full to 0. Stored pixels are not zeroed; they are overwritten on reload.
- wgt_we writes weight[wgt_addr]. An address >= K*K is ignored.
- start & img_full: total_sum to 0, (r,c) to (0,0), go to MAC. start without img_full is ignored.
- Priority within one cycle: clear > start > row acceptance. A weight write in the same cycle as an accepted start lands before the run.

MAC:
- One product per cycle: acc += img[r+kr][c+kc] * weight[kr*K+kc], with (kr,kc) raster-ordered.
- acc starts at 0. After K*K cycles, go to EMIT.

EMIT:
- out_valid=1. out_data, out_row, out_col and out_last are registered and held stable until out_ready.
- On out_valid & out_ready: total_sum += out_data.
  - If last: go to DONE.
  - Otherwise advance c, wrapping at OUT_N to r+1, and go to MAC.
- Latency: first out_valid K*K+1 cycles after the start cycle. Each subsequent output follows K*K cycles after acceptance.

DONE:
- done=1 for exactly one cycle, then IDLE.
- The image and weights are retained, so a re-start repeats the run.

Gating:
- busy=1 in MAC and EMIT.
- While not in IDLE: row_ready=0, and clear, start and wgt_we are ignored.

Arithmetic: all unsigned. ACC_W and SUM_W are sized so no saturation or wrap is possible.

Decomposition:
- Package conv_pkg: state enum (IDLE, MAC, EMIT, DONE) and clog2-based width functions for ACC_W, SUM_W and the index widths.
- Sub-module conv_mac: multiply-accumulate datapath with ports clr, en, pix, wgt, acc.
- conv_engine holds the FSM, image/weight storage, index counters and the output register.

Test Plan:
1. Load 6 rows of 6'b111111, default weights, start, out_ready=1 -> 16 outputs, each 9. Raster order (0,0)..(3,3); out_last only on (3,3); total_sum=144; done single pulse; first out_valid 10 cycles after start.
2. Write weight[4]=1 and all others 0; checkerboard image pixel(r,c)=(r+c)%2 -> out(r,c)=(r+c)%2; total_sum=8.
3. Backpressure: hold out_ready=0 for 5 cycles on output (1,2) -> out_valid stays 1, out_data/row/col stable; total_sum unchanged until acceptance.
4. Start after 4 rows -> ignored, busy stays 0. Load the 2 remaining rows, then a 7th row_valid -> row_ready=0, row not taken. clear -> img_full=0, row_ready=1.
5. During MAC: wgt_we to addr 0 with 4'hF, plus start and clear -> all ignored; the run matches scenario 1; afterwards weight[0] is still 1.
6. Assert rst mid-MAC for 1 cycle (async, between clock edges) -> outputs reset immediately, no done pulse. weight[0] reads back 1; img_full=0.
